// File: rtl/uart_rx_esc.sv
// 8N1 UART receiver with a one-byte escape layer (ESC ESC -> literal ESC, ESC x -> command x).
// Define UART_RX_FIFO_EN for a 4-deep FWFT output FIFO instead of a single holding register.
module uart_rx_esc #(
    parameter logic [7:0] ESC       = 8'hB1,
    parameter int         CLK_RATE  = 100000000,
    parameter int         BAUD_RATE = 3000000
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       RX_I,
    input  logic       READ_I,
    output logic [7:0] DATA_O,
    output logic       CMD_O,
    output logic       VALID_O,
    output logic       OVERRUN_O,
    output logic       FRAME_ERR_O
);
    localparam int DIV  = CLK_RATE / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_sync1, r_rx_s, r_rx_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_esc_pend;
    logic            r_ovr, r_ferr;
    logic            w_fall, w_tick, w_byte_done, w_frame_err;
    logic            w_emit, w_emit_cmd, w_pop, w_full;

    assign w_fall = r_rx_prev & ~r_rx_s;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1   <= RX_I;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            r_state   <= w_state_nxt;
            if (w_tick || r_state == IDLE) r_cnt <= '0;
            else                           r_cnt <= r_cnt + 1'b1;
            if (r_state == START)               r_bit <= '0;
            else if (r_state == DATA && w_tick) r_bit <= r_bit + 1'b1;
            if (r_state == DATA && w_tick) r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            IDLE: if (w_fall) w_state_nxt = START;
            START: if (r_cnt == CW'(HALF - 1)) begin
                w_tick      = 1'b1;
                w_state_nxt = r_rx_s ? IDLE : DATA;
            end
            DATA: if (r_cnt == CW'(DIV - 1)) begin
                w_tick = 1'b1;
                if (r_bit == 3'd7) w_state_nxt = STOP;
            end
            STOP: if (r_cnt == CW'(DIV - 1)) begin
                w_tick = 1'b1;
                if (r_rx_s) begin
                    w_byte_done = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_frame_err = 1'b1;
                    w_state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (r_rx_s) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Escape decode: a lone ESC only arms the pending flag; the next byte decides.
    always_comb begin
        w_emit     = 1'b0;
        w_emit_cmd = 1'b0;
        if (w_byte_done) begin
            if (r_esc_pend) begin
                w_emit     = 1'b1;
                w_emit_cmd = (r_shift != ESC);
            end else if (r_shift != ESC) begin
                w_emit = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_esc_pend <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_ferr <= w_frame_err;
            if (w_frame_err)      r_esc_pend <= 1'b0;
            else if (w_byte_done) r_esc_pend <= ~r_esc_pend && (r_shift == ESC);
            if (w_emit && w_full && !w_pop) r_ovr <= 1'b1;
        end
    end

    assign w_pop       = READ_I & VALID_O;
    assign OVERRUN_O   = r_ovr;
    assign FRAME_ERR_O = r_ferr;

`ifdef UART_RX_FIFO_EN
    logic [8:0] r_mem [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_fcnt;
    logic       w_push;

    assign w_full  = r_fcnt[2];
    assign w_push  = w_emit && (!w_full || w_pop);
    assign VALID_O = (r_fcnt != 3'd0);
    assign CMD_O   = r_mem[r_rp][8];
    assign DATA_O  = r_mem[r_rp][7:0];

    // When full, a simultaneous push lands in the slot being popped this cycle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= {w_emit_cmd, r_shift};
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end
`else
    logic [7:0] r_dat;
    logic       r_cmd, r_vld;

    assign w_full  = r_vld;
    assign VALID_O = r_vld;
    assign CMD_O   = r_cmd;
    assign DATA_O  = r_dat;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_dat <= '0;
            r_cmd <= 1'b0;
            r_vld <= 1'b0;
        end else if (w_emit && (!r_vld || w_pop)) begin
            r_dat <= r_shift;
            r_cmd <= w_emit_cmd;
            r_vld <= 1'b1;
        end else if (w_pop) begin
            r_vld <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_esc.sv
// Directed bench for uart_rx_esc at DIV=8: escape decode, frame error, overrun, glitch and reset.
module tb_uart_rx_esc;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd;
    logic [7:0] data;
    logic       cmd, vld, ovr, ferr;

    int n_vec  = 0;
    int n_miss = 0;
    int n_rise = 0;
    int n_ferr = 0;
    logic vld_q = 1'b0;
    int base_rise, base_ferr;

    uart_rx_esc #(.ESC(8'hB1), .CLK_RATE(1500), .BAUD_RATE(180)) dut (
        .CLK_I(clk), .RST_I(rst), .RX_I(rx), .READ_I(rd),
        .DATA_O(data), .CMD_O(cmd), .VALID_O(vld),
        .OVERRUN_O(ovr), .FRAME_ERR_O(ferr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vld && !vld_q) n_rise++;
        vld_q = vld;
        if (ferr) n_ferr++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; one 8N1 frame is 80 cycles, followed by 4 idle cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (8) @(negedge clk);
        end
        rx = stop_bit;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic mark;
        base_rise = n_rise;
        base_ferr = n_ferr;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_data", data, 8'h00);
        check_eq("rst_cmd", cmd, 1'b0);
        check_eq("rst_valid", vld, 1'b0);
        check_eq("rst_ovr", ovr, 1'b0);
        check_eq("rst_ferr", ferr, 1'b0);

        mark();
        send_byte(8'h41, 1'b1);
        check_eq("b41_count", n_rise - base_rise, 1);
        check_eq("b41_valid", vld, 1'b1);
        check_eq("b41_data", data, 8'h41);
        check_eq("b41_cmd", cmd, 1'b0);
        pop();
        check_eq("b41_popped", vld, 1'b0);

        mark();
        send_byte(8'hB1, 1'b1);
        send_byte(8'h22, 1'b1);
        check_eq("esc22_count", n_rise - base_rise, 1);
        check_eq("esc22_data", data, 8'h22);
        check_eq("esc22_cmd", cmd, 1'b1);
        pop();

        mark();
        send_byte(8'hB1, 1'b1);
        send_byte(8'hB1, 1'b1);
        check_eq("escesc_count", n_rise - base_rise, 1);
        check_eq("escesc_data", data, 8'hB1);
        check_eq("escesc_cmd", cmd, 1'b0);
        pop();

        mark();
        send_byte(8'hAA, 1'b0);
        check_eq("ferr_pulses", n_ferr - base_ferr, 1);
        check_eq("ferr_count", n_rise - base_rise, 0);
        check_eq("ferr_valid", vld, 1'b0);
        send_byte(8'h55, 1'b1);
        check_eq("after_ferr_valid", vld, 1'b1);
        check_eq("after_ferr_data", data, 8'h55);
        check_eq("after_ferr_cmd", cmd, 1'b0);
        pop();

        // A frame error between ESC and the next byte must drop the pending escape.
        mark();
        send_byte(8'hB1, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h22, 1'b1);
        check_eq("escclr_count", n_rise - base_rise, 1);
        check_eq("escclr_data", data, 8'h22);
        check_eq("escclr_cmd", cmd, 1'b0);
        pop();

        pop();
        check_eq("idle_read_valid", vld, 1'b0);

        // Pop on the exact cycle the next byte is written (stop sample at cycle 78).
        send_byte(8'h10, 1'b1);
        fork
            send_byte(8'h33, 1'b1);
            begin
                repeat (78) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        check_eq("pushpop_valid", vld, 1'b1);
        check_eq("pushpop_data", data, 8'h33);
        check_eq("pushpop_ovr", ovr, 1'b0);
        pop();
        check_eq("pushpop_empty", vld, 1'b0);

        mark();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("glitch_count", n_rise - base_rise, 0);
        check_eq("glitch_ferr", n_ferr - base_ferr, 0);
        send_byte(8'h5A, 1'b1);
        check_eq("post_glitch_data", data, 8'h5A);
        check_eq("post_glitch_count", n_rise - base_rise, 1);
        pop();

`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
        check_eq("ovr_flag", ovr, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("fifo_valid", vld, 1'b1);
            check_eq("fifo_data", data, 8'h10 + 8'(i));
            pop();
        end
        check_eq("fifo_empty", vld, 1'b0);
`else
        send_byte(8'h10, 1'b1);
        send_byte(8'h11, 1'b1);
        check_eq("ovr_data", data, 8'h10);
        check_eq("ovr_flag", ovr, 1'b1);
        pop();
        check_eq("ovr_empty", vld, 1'b0);
`endif

        // Reset in the middle of a frame; the tail must not produce a byte.
        mark();
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("midrst_count", n_rise - base_rise, 0);
        check_eq("midrst_valid", vld, 1'b0);
        check_eq("midrst_data", data, 8'h00);
        check_eq("midrst_cmd", cmd, 1'b0);
        check_eq("midrst_ovr", ovr, 1'b0);
        check_eq("midrst_ferr", n_ferr - base_ferr, 0);
        send_byte(8'hC3, 1'b1);
        check_eq("post_rst_data", data, 8'hC3);
        check_eq("post_rst_valid", vld, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/uart_rx_esc.md
UART_RX_ESC -- requirements
Module: uart_rx_esc

Interface
REQ-001 SHALL have parameter ESC, default 8'hB1: escape byte value.
REQ-002 SHALL have parameter CLK_RATE, default 100000000: CLK_I frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 3000000: serial bit rate; DIV = CLK_RATE/BAUD_RATE (floor), DIV >= 4.
REQ-004 SHALL have CLK_I  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have RST_I  in  1  reset, synchronous, active-high.
REQ-006 SHALL have RX_I  in  1  asynchronous serial input, idle high.
REQ-007 SHALL have READ_I  in  1  consumer pops the current output byte.
REQ-008 SHALL have DATA_O  out  8  received byte.
REQ-009 SHALL have CMD_O  out  1  DATA_O is a command byte, i.e. it followed an ESC.
REQ-010 SHALL have VALID_O  out  1  DATA_O/CMD_O valid.
REQ-011 SHALL have OVERRUN_O  out  1  sticky: a byte was dropped.
REQ-012 SHALL have FRAME_ERR_O  out  1  one-cycle pulse on a bad stop bit.

Function
REQ-013 SHALL pass RX_I through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: falling edge of synchronized RX -> START with bit counter cleared.
REQ-016 START: sample at cycle DIV/2; 1 -> IDLE (glitch rejected); 0 -> DATA.
REQ-017 DATA: sample every DIV cycles, 8 bits, LSB first.
REQ-018 STOP: sample after DIV cycles; 1 -> byte complete, IDLE; 0 -> FRAME_ERR_O pulse, byte discarded, WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until synchronized RX = 1, then IDLE.
REQ-020 Escape layer, on byte b completion: no ESC pending and b==ESC -> set pending, emit nothing.
REQ-021 Pending and b==ESC -> emit ESC with CMD=0, clear pending.
REQ-022 Pending and b!=ESC -> emit b with CMD=1, clear pending.
REQ-023 Not pending and b!=ESC -> emit b with CMD=0.
REQ-024 A frame error SHALL clear ESC pending.
REQ-025 An emitted byte SHALL appear on VALID_O the cycle after the stop-bit sample.
REQ-026 Handshake: pop when READ_I & VALID_O; READ_I without VALID_O is ignored.
REQ-027 Emit while the output is full and no pop in the same cycle: new byte dropped, OVERRUN_O set until reset.
REQ-028 Emit and pop in the same cycle SHALL both succeed; no overrun.

Reset
REQ-029 RST_I SHALL clear DATA_O, CMD_O, VALID_O, OVERRUN_O, FRAME_ERR_O and ESC pending, and set the FSM to IDLE.
REQ-030 RST_I SHALL set the synchronizer flops to 1.
REQ-031 RST_I mid-frame SHALL discard the partial byte.
REQ-032 After RST_I, reception resumes at the next falling edge.

Configuration
REQ-033 Macro UART_RX_FIFO_EN undefined: output storage is one holding register; full when VALID_O=1.
REQ-034 UART_RX_FIFO_EN defined: output storage is a 4-entry first-word-fall-through FIFO of {CMD,DATA}; DATA_O/CMD_O show the head; VALID_O = not empty; full at 4 entries; REQ-027 and REQ-028 apply to the FIFO.

Verification (CLK_RATE=1500, BAUD_RATE=180, DIV=8)
REQ-035 Send 0x41 -> VALID_O=1, DATA_O=0x41, CMD_O=0; READ_I pulse -> VALID_O=0 the next cycle.
REQ-036 Send 0xB1, 0x22 -> exactly one output, DATA_O=0x22, CMD_O=1.
REQ-037 Send 0xB1, 0xB1 -> exactly one output, DATA_O=0xB1, CMD_O=0.
REQ-038 Send a frame with stop bit 0 -> one-cycle FRAME_ERR_O, no VALID_O; a following 0x55 is received correctly.
REQ-039 Send 0x10, 0x11 without READ_I -> DATA_O=0x10, OVERRUN_O=1; with FIFO, 5 bytes 0x10..0x14 -> 0x10..0x13 popped in order, OVERRUN_O=1.
REQ-040 Drive RX_I low for 2 cycles while idle -> no byte, FSM back in IDLE; assert RST_I mid-byte -> no output, all outputs 0.
